button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 107 ++++++++++
 tb/tb_button_conditioner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and auto-repeat an active-low push button.
// Outputs are registered; the repeat FSM follows the debouncer's same-edge accept decisions.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat,
    output logic btn_event
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW   = $clog2(RMAX);
    localparam logic [DW-1:0] DEB_T  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HOLD_T = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_T  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          level_q, level_d, press_q, press_d, release_q, release_d;
    logic          repeat_q, repeat_d, event_q, event_d;
    logic          s, accept, acc_press, acc_rel;

    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        s         = ~sync2_q;
        accept    = (s != level_q) && (deb_cnt_q == DEB_T);
        deb_cnt_d = (s == level_q || accept) ? '0 : deb_cnt_q + 1'b1;
        level_d   = accept ? s : level_q;
        acc_press = accept & s;
        acc_rel   = accept & ~s;
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        repeat_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_press) begin
                    state_d   = HOLD;
                    rep_cnt_d = '0;
                end
            end
            HOLD, REPEAT: begin
                // release wins over a terminal count on the same edge
                if (acc_rel) begin
                    state_d   = IDLE;
                    rep_cnt_d = '0;
                end else if (rep_cnt_q == (state_q == HOLD ? HOLD_T : REP_T)) begin
                    state_d   = REPEAT;
                    rep_cnt_d = '0;
                    repeat_d  = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rep_cnt_d = '0;
            end
        endcase
        press_d   = acc_press;
        release_d = acc_rel;
        event_d   = acc_press | repeat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_cnt_q <= '0;
            rep_cnt_q <= '0;
            state_q   <= IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_cnt_q <= deb_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            event_q   <= event_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_repeat  = repeat_q;
    assign btn_event   = event_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus, a window/arithmetic reference model checked every
// cycle, and literal edge-number expectations for each scenario.
module tb_button_conditioner;
    localparam int DEB = 4;
    localparam int HOLD = 10;
    localparam int REP = 3;

    logic clk = 1'b0;
    logic rst_n, key_n;
    logic btn_level, btn_press, btn_release, btn_repeat, btn_event;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .btn_event(btn_event)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: s is the key seen through two flops; a new level is accepted once the
    // last DEB samples all disagree with it; repeats fall at press+HOLD+k*REP while held.
    bit m_k1, m_k2, m_level, m_press, m_rel, m_rep, m_event, have_press, s, all_diff;
    bit sq[$];
    int press_t, d, tnow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k1 = 1; m_k2 = 1; sq.delete();
            m_level = 0; m_press = 0; m_rel = 0; m_rep = 0; m_event = 0;
            have_press = 0; press_t = 0;
        end else begin
            tnow = cyc + 1;
            s = ~m_k2;
            sq.push_back(s);
            if (sq.size() > DEB) void'(sq.pop_front());
            all_diff = (sq.size() == DEB);
            foreach (sq[i]) if (sq[i] == m_level) all_diff = 0;
            m_press = all_diff && !m_level;
            m_rel   = all_diff && m_level;
            if (all_diff) m_level = ~m_level;
            if (m_press) begin
                press_t = tnow;
                have_press = 1;
            end
            d = tnow - press_t;
            m_rep = have_press && m_level && !m_press && d >= HOLD && ((d - HOLD) % REP) == 0;
            m_event = m_press | m_rep;
            m_k2 = m_k1;
            m_k1 = key_n;
        end
    end

    int press_q[$], rel_q[$], rep_q[$], evt_q[$];

    always @(negedge clk) begin
        chk("level", btn_level, m_level);
        chk("press", btn_press, m_press);
        chk("release", btn_release, m_rel);
        chk("repeat", btn_repeat, m_rep);
        chk("event", btn_event, m_event);
        if (btn_press) press_q.push_back(cyc);
        if (btn_release) rel_q.push_back(cyc);
        if (btn_repeat) rep_q.push_back(cyc);
        if (btn_event) evt_q.push_back(cyc);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear();
        press_q.delete(); rel_q.delete(); rep_q.delete(); evt_q.delete();
    endtask

    function automatic int first(input int q[$]);
        return q.size() > 0 ? q[0] : -1;
    endfunction

    int e0, p, r0, f, n, m;

    initial begin
        rst_n = 1'b0;
        key_n = 1'b1;
        cycles(3);
        chk("rst_level", btn_level, 0);
        chk("rst_event", btn_event, 0);
        rst_n = 1'b1;
        cycles(10);
        chk("idle_press_cnt", press_q.size(), 0);
        chk("idle_rel_cnt", rel_q.size(), 0);

        // clean press, then hold for 30 cycles
        clear();
        e0 = cyc + 1;
        key_n = 1'b0;
        cycles(35);
        p = e0 + 5;
        chk("press_cnt", press_q.size(), 1);
        chk("press_time", first(press_q), p);
        chk("press_event_time", first(evt_q), p);
        chk("press_no_release", rel_q.size(), 0);
        chk("hold_rep_cnt", rep_q.size(), 7);
        chk("hold_evt_cnt", evt_q.size(), 8);
        foreach (rep_q[i]) chk("hold_rep_time", rep_q[i], p + 10 + 3 * i);
        key_n = 1'b1;
        r0 = cyc + 1;
        cycles(10);
        chk("release_cnt", rel_q.size(), 1);
        chk("release_time", first(rel_q), r0 + 5);
        chk("release_level", btn_level, 0);

        // glitch of 3 cycles
        clear();
        key_n = 1'b0;
        cycles(3);
        key_n = 1'b1;
        cycles(12);
        chk("glitch_level", btn_level, 0);
        chk("glitch_pulses", press_q.size() + rel_q.size() + rep_q.size() + evt_q.size(), 0);

        // bounce every 2 cycles for 20 cycles, then settle low
        clear();
        for (int i = 0; i < 20; i++) begin
            key_n = ((i / 2) % 2) != 0;
            cycles(1);
        end
        key_n = 1'b0;
        f = cyc + 1;
        cycles(8);
        chk("bounce_press_cnt", press_q.size(), 1);
        chk("bounce_press_time", first(press_q), f + 5);
        key_n = 1'b1;
        cycles(10);

        // release accepted on the HOLD terminal edge
        clear();
        n = cyc;
        key_n = 1'b0;
        p = n + 6;
        cycles(10);
        key_n = 1'b1;
        cycles(15);
        chk("rvr_press_time", first(press_q), p);
        chk("rvr_release_time", first(rel_q), p + 10);
        chk("rvr_no_repeat", rep_q.size(), 0);
        chk("rvr_evt_cnt", evt_q.size(), 1);

        // reset while in REPEAT, key held through reset
        clear();
        key_n = 1'b0;
        p = cyc + 6;
        cycles(20);
        chk("pre_rst_rep_cnt", rep_q.size(), 2);
        rst_n = 1'b0;
        cycles(1);
        chk("inrst_level", btn_level, 0);
        chk("inrst_outs", {btn_press, btn_release, btn_repeat, btn_event}, 0);
        cycles(2);
        m = cyc;
        rst_n = 1'b1;
        clear();
        cycles(20);
        chk("rerst_press_time", first(press_q), m + 6);
        chk("rerst_rep_time", first(rep_q), m + 16);
        chk("rerst_rep_cnt", rep_q.size(), 2);
        key_n = 1'b1;
        cycles(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
